// File: rtl/bcd_time_counter.sv
// Time-of-day core: divides CP into a 1 s tick and keeps hh:mm:ss as packed BCD.
// Supports 24 h or 12 h+PM display and a manual time-set mode for the user keys.
module bcd_time_counter #(
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned MODE_12H = 0
) (
   input  logic       CP,
   input  logic       RST,
   input  logic       SET_EN,
   input  logic [1:0] SET_SEL,
   input  logic       SET_INC,
   output logic [7:0] TIME_H,
   output logic [7:0] TIME_M,
   output logic [7:0] TIME_S,
   output logic       PM,
   output logic       SEC_PULSE,
   output logic       DAY_PULSE
);

   localparam int unsigned PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [7:0]  HOUR_RST  = (MODE_12H != 0) ? 8'h12 : 8'h00;

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    hour_q, hour_d;
   logic [7:0]    min_q, min_d;
   logic [7:0]    sec_q, sec_d;
   logic          pm_q, pm_d;
   logic          sec_pulse_q, sec_pulse_d;
   logic          day_pulse_q, day_pulse_d;

   logic [7:0]    hour_nx;
   logic          hour_pm_flip;
   logic          hour_day_wrap;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
      return (v == 8'h59) ? 8'h00 : bcd_inc(v);
   endfunction

   // Next hour value, shared by the ripple carry and the set-mode hour key.
   always_comb begin
      hour_nx       = bcd_inc(hour_q);
      hour_pm_flip  = 1'b0;
      hour_day_wrap = 1'b0;
      if (MODE_12H != 0) begin
         if (hour_q == 8'h12) begin
            hour_nx = 8'h01;
         end else if (hour_q == 8'h11) begin
            hour_pm_flip  = 1'b1;
            hour_day_wrap = pm_q;
         end
      end else if (hour_q == 8'h23) begin
         hour_nx       = 8'h00;
         hour_day_wrap = 1'b1;
      end
   end

   always_comb begin
      presc_d     = presc_q;
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      pm_d        = pm_q;
      sec_pulse_d = 1'b0;
      day_pulse_d = 1'b0;

      if (SET_EN) begin
         presc_d = '0;
         if (SET_INC) begin
            unique case (SET_SEL)
               2'b01: begin
                  hour_d = hour_nx;
                  pm_d   = pm_q ^ hour_pm_flip;
               end
               2'b10:   min_d = bcd_inc59(min_q);
               2'b11:   sec_d = 8'h00;
               default: ;
            endcase
         end
      end else if (presc_q == PRESC_MAX) begin
         presc_d     = '0;
         sec_pulse_d = 1'b1;
         sec_d       = bcd_inc59(sec_q);
         if (sec_q == 8'h59) begin
            min_d = bcd_inc59(min_q);
            if (min_q == 8'h59) begin
               hour_d      = hour_nx;
               pm_d        = pm_q ^ hour_pm_flip;
               day_pulse_d = hour_day_wrap;
            end
         end
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge CP) begin
      if (RST) begin
         presc_q     <= '0;
         hour_q      <= HOUR_RST;
         min_q       <= 8'h00;
         sec_q       <= 8'h00;
         pm_q        <= 1'b0;
         sec_pulse_q <= 1'b0;
         day_pulse_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         pm_q        <= pm_d;
         sec_pulse_q <= sec_pulse_d;
         day_pulse_q <= day_pulse_d;
      end
   end

   assign TIME_H    = hour_q;
   assign TIME_M    = min_q;
   assign TIME_S    = sec_q;
   assign PM        = (MODE_12H != 0) && pm_q;
   assign SEC_PULSE = sec_pulse_q;
   assign DAY_PULSE = day_pulse_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: 24 h and 12 h instances share stimulus and are
// checked every cycle against a seconds-of-day model, plus literal spot checks.
module tb_bcd_time_counter;

   localparam int unsigned TD = 4;

   logic       cp = 1'b0;
   logic       rst = 1'b1;
   logic       set_en = 1'b0;
   logic [1:0] set_sel = 2'b00;
   logic       set_inc = 1'b0;

   logic [7:0] a_h, a_m, a_s, b_h, b_m, b_s;
   logic       a_pm, a_sp, a_dp, b_pm, b_sp, b_dp;

   int checks = 0;
   int failures = 0;

   bcd_time_counter #(.TICK_DIV(TD), .MODE_12H(0)) dut24 (
      .CP(cp), .RST(rst), .SET_EN(set_en), .SET_SEL(set_sel), .SET_INC(set_inc),
      .TIME_H(a_h), .TIME_M(a_m), .TIME_S(a_s), .PM(a_pm), .SEC_PULSE(a_sp),
      .DAY_PULSE(a_dp)
   );

   bcd_time_counter #(.TICK_DIV(TD), .MODE_12H(1)) dut12 (
      .CP(cp), .RST(rst), .SET_EN(set_en), .SET_SEL(set_sel), .SET_INC(set_inc),
      .TIME_H(b_h), .TIME_M(b_m), .TIME_S(b_s), .PM(b_pm), .SEC_PULSE(b_sp),
      .DAY_PULSE(b_dp)
   );

   always #5 cp = ~cp;

   // Time kept as seconds since midnight; 12 h rendering derived from the 24 h hour.
   typedef struct {
      bit valid;
      int tod;
      int presc;
      bit sp;
      bit dp;
   } model_t;

   model_t m;

   function automatic model_t model_step(input model_t c, input logic r, input logic en,
                                         input logic [1:0] sel, input logic inc);
      model_t n = c;
      int h, mi, s;
      n.sp = 1'b0;
      n.dp = 1'b0;
      if (r) begin
         n.valid = 1'b1;
         n.tod   = 0;
         n.presc = 0;
      end else if (en) begin
         n.presc = 0;
         h  = c.tod / 3600;
         mi = (c.tod / 60) % 60;
         s  = c.tod % 60;
         if (inc) begin
            case (sel)
               2'd1:    h  = (h + 1) % 24;
               2'd2:    mi = (mi + 1) % 60;
               2'd3:    s  = 0;
               default: ;
            endcase
         end
         n.tod = h * 3600 + mi * 60 + s;
      end else if (c.presc == TD - 1) begin
         n.presc = 0;
         n.sp    = 1'b1;
         n.dp    = (c.tod == 86399);
         n.tod   = (c.tod + 1) % 86400;
      end else begin
         n.presc = c.presc + 1;
      end
      return n;
   endfunction

   always @(posedge cp) m <= model_step(m, rst, set_en, set_sel, set_inc);

   function automatic logic [7:0] bcd(input int n);
      return 8'(((n / 10) * 16) + (n % 10));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then compare both instances against the model.
   task automatic step(input logic r, input logic e, input logic [1:0] sel, input logic inc);
      int h, h12, mi, s;
      rst     = r;
      set_en  = e;
      set_sel = sel;
      set_inc = inc;
      @(negedge cp);
      if (m.valid) begin
         h   = m.tod / 3600;
         mi  = (m.tod / 60) % 60;
         s   = m.tod % 60;
         h12 = (h % 12 == 0) ? 12 : h % 12;
         check("model24", {5'b0, a_h, a_m, a_s, a_pm, a_sp, a_dp},
               {5'b0, bcd(h), bcd(mi), bcd(s), 1'b0, m.sp, m.dp});
         check("model12", {5'b0, b_h, b_m, b_s, b_pm, b_sp, b_dp},
               {5'b0, bcd(h12), bcd(mi), bcd(s), 1'(h >= 12), m.sp, m.dp});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 2'd0, 1'b0);
   endtask

   // Leaves the clock at hh:mm:59 (24 h hour), counting enabled.
   task automatic preload(input int h, input int mi);
      step(1'b1, 1'b0, 2'd0, 1'b0);
      step(1'b0, 1'b1, 2'd3, 1'b1);
      repeat (h) step(1'b0, 1'b1, 2'd1, 1'b1);
      repeat (mi) step(1'b0, 1'b1, 2'd2, 1'b1);
      idle(59 * TD);
   endtask

   logic en_r;

   initial begin
      @(negedge cp);
      // Reset state and first tick.
      step(1'b1, 1'b0, 2'd0, 1'b0);
      check("rst_s24", {24'b0, a_s}, 32'h00);
      check("rst_h12", {23'b0, b_h, b_pm}, {23'b0, 8'h12, 1'b0});
      idle(TD - 1);
      check("pre_tick_s", {23'b0, a_s, a_sp}, {23'b0, 8'h00, 1'b0});
      idle(1);
      check("tick_s", {23'b0, a_s, a_sp}, {23'b0, 8'h01, 1'b1});
      idle(1);
      check("tick_sp_one", {31'b0, a_sp}, 32'h0);

      // Ripple carries.
      preload(0, 59);
      check("pre_005959", {8'b0, a_h, a_m, a_s}, 32'h005959);
      idle(TD - 1);
      check("hold_m59", {24'b0, a_m}, 32'h59);
      idle(1);
      check("roll_010000", {8'b0, a_h, a_m, a_s}, 32'h010000);
      preload(23, 59);
      idle(TD);
      check("day_roll", {7'b0, a_h, a_m, a_s, a_dp}, {7'b0, 24'h000000, 1'b1});
      idle(1);
      check("day_pulse_one", {31'b0, a_dp}, 32'h0);

      // Minute sweep near the hour boundary.
      preload(0, 58);
      idle(52 * TD);
      check("sweep_5951", {16'b0, a_m, a_s}, 32'h5951);
      idle(8 * TD);

      // Set mode.
      step(1'b0, 1'b1, 2'd3, 1'b1);
      check("set_sclr", {23'b0, a_s, a_sp}, {23'b0, 8'h00, 1'b0});
      step(1'b1, 1'b0, 2'd0, 1'b0);
      repeat (58) step(1'b0, 1'b1, 2'd2, 1'b1);
      check("set_m58", {24'b0, a_m}, 32'h58);
      step(1'b0, 1'b1, 2'd2, 1'b1);
      check("set_m59", {24'b0, a_m}, 32'h59);
      step(1'b0, 1'b1, 2'd2, 1'b1);
      check("set_m00", {16'b0, a_h, a_m}, 32'h0000);
      step(1'b0, 1'b1, 2'd2, 1'b1);
      check("set_m01", {16'b0, a_h, a_m}, 32'h0001);
      repeat (23) step(1'b0, 1'b1, 2'd1, 1'b1);
      check("set_h23", {24'b0, a_h}, 32'h23);
      step(1'b0, 1'b1, 2'd1, 1'b1);
      check("set_h00", {23'b0, a_h, a_dp}, 32'h0);
      repeat (3 * TD) step(1'b0, 1'b1, 2'd0, 1'b1);

      // INC ignored while counting; release mid-second.
      repeat (2 * TD) step(1'b0, 1'b0, 2'd1, 1'b1);
      idle(2);
      step(1'b0, 1'b1, 2'd0, 1'b0);
      idle(TD + 3);

      // Reset wins over rollover and set-mode adjust.
      preload(23, 59);
      idle(TD - 1);
      step(1'b1, 1'b0, 2'd0, 1'b0);
      check("rst_vs_roll", {7'b0, a_h, a_m, a_s, a_dp}, 32'h0);
      step(1'b0, 1'b1, 2'd1, 1'b1);
      step(1'b1, 1'b1, 2'd1, 1'b1);
      check("rst_vs_inc", {23'b0, a_h, b_pm}, {23'b0, 8'h00, 1'b0});

      // 12 h noon crossing.
      preload(11, 59);
      check("am_115959", {7'b0, b_h, b_m, b_s, b_pm}, {7'b0, 24'h115959, 1'b0});
      idle(TD);
      check("noon", {6'b0, b_h, b_m, b_s, b_pm, b_dp}, {6'b0, 24'h120000, 1'b1, 1'b0});

      // Randomised traffic.
      en_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) en_r = ~en_r;
         step(1'(($urandom_range(0, 299) == 0)), en_r, 2'($urandom),
              1'(($urandom_range(0, 2) == 0)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
